// File: rtl/call_panel_if.sv
// Button / floor / lamp / door bundle between the call panel and its environment.
interface call_panel_if;
  logic       btn1;
  logic       btn2;
  logic       btn3;
  logic [1:0] floor;
  logic       moving;
  logic       led1;
  logic       led2;
  logic       led3;
  logic       door_open;
  logic [1:0] state_o;

  modport master (
    output btn1, btn2, btn3, floor, moving,
    input  led1, led2, led3, door_open, state_o
  );

  modport slave (
    input  btn1, btn2, btn3, floor, moving,
    output led1, led2, led3, door_open, state_o
  );
endinterface

// File: rtl/call_panel.sv
// call_panel: button synchronisation, per-floor request lamps and door dwell FSM.
// Optional macro REQ_CANCEL_EN: a press on a lit lamp toggles it off.
module call_panel #(
  parameter logic [1:0] labelF1      = 2'b00,
  parameter logic [1:0] labelF2      = 2'b01,
  parameter logic [1:0] labelF3      = 2'b10,
  parameter int         DWELL_CYCLES = 8
) (
  input logic         clk,
  input logic         rst_n,
  call_panel_if.slave bus
);

  localparam int CW = $clog2(DWELL_CYCLES + 1);
  localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES - 1);
  localparam logic [2:0][1:0] LBL = {labelF3, labelF2, labelF1};

  // OPEN = 2'b01 so door_open is a straight flop bit (glitch-free).
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OPEN  = 2'b01,
    CLOSE = 2'b10
  } state_t;

  logic [2:0]    btn_raw;
  logic [2:0]    sync1_q, sync1_d;
  logic [2:0]    sync2_q, sync2_d;
  logic [2:0]    prev_q, prev_d;
  logic [2:0]    press_q, press_d;
  logic [2:0]    led_q, led_d;
  logic [CW-1:0] cnt_q, cnt_d;
  state_t        state_q, state_d;

  logic [2:0]    here;
  logic [2:0]    svc_clr;
  logic [2:0]    rearm_blk;
  logic [2:0]    eff_press;

  assign btn_raw = {bus.btn3, bus.btn2, bus.btn1};

  // Current floor as a one-hot lane mask; 2'b11 matches no lane.
  always_comb begin
    for (int i = 0; i < 3; i++) here[i] = (bus.floor == LBL[i]);
  end

  // Two-flop synchroniser, then a registered rising-edge pulse per button.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    press_d = sync2_q & ~prev_q;
  end

  // Door FSM: service entry, dwell countdown, re-arm and moving abort.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    svc_clr   = '0;
    rearm_blk = '0;
    case (state_q)
      IDLE: begin
        if (!bus.moving && |(here & (led_q | press_q))) begin
          state_d = OPEN;
          cnt_d   = DWELL_LOAD;
          svc_clr = here;
        end
      end
      OPEN: begin
        // Presses for the floor being served re-arm instead of lighting.
        rearm_blk = here;
        if (bus.moving) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (|(here & press_q)) begin
          cnt_d = DWELL_LOAD;
        end else if (cnt_q == '0) begin
          state_d = CLOSE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      CLOSE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lamp update: set (or toggle) on press, cleared when a service starts.
  always_comb begin
    eff_press = press_q & ~rearm_blk;
`ifdef REQ_CANCEL_EN
    led_d = (led_q ^ eff_press) & ~svc_clr;
`else
    led_d = (led_q | eff_press) & ~svc_clr;
`endif
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      press_q <= '0;
      led_q   <= '0;
      cnt_q   <= '0;
      state_q <= IDLE;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      press_q <= press_d;
      led_q   <= led_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign bus.led1      = led_q[0];
  assign bus.led2      = led_q[1];
  assign bus.led3      = led_q[2];
  assign bus.door_open = state_q[0];
  assign bus.state_o   = state_q;

endmodule

// File: tb/tb_call_panel.sv
// Self-checking bench for call_panel: door windows checked against a scoreboard,
// lamps and FSM state checked at fixed points of each scenario.
module tb_call_panel;

  logic clk;
  logic rst_n;
  call_panel_if bus();

  call_panel dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int         len;
    logic [1:0] after;
  } door_exp_t;

  door_exp_t exp_q[$];
  int n_run;
  int n_fail;
  int run_len;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [2:0] m);
    {bus.btn3, bus.btn2, bus.btn1} = m;
    step();
    {bus.btn3, bus.btn2, bus.btn1} = 3'b000;
    repeat (4) step();
  endtask

  function automatic int leds();
    return int'({bus.led3, bus.led2, bus.led1});
  endfunction

  // Door monitor: measures each door_open window and checks it against the queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      run_len = 0;
    end else if (bus.door_open) begin
      run_len++;
    end else if (run_len > 0) begin
      if (exp_q.size() == 0) begin
        chk("door_unexpected", run_len, 0);
      end else begin
        door_exp_t e;
        e = exp_q.pop_front();
        chk("door_len", run_len, e.len);
        chk("door_after_state", int'(bus.state_o), int'(e.after));
      end
      run_len = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    n_run = 0; n_fail = 0; run_len = 0;
    rst_n = 1'b0;
    bus.btn1 = 0; bus.btn2 = 0; bus.btn3 = 0;
    bus.floor = 2'b00; bus.moving = 1'b1;
    repeat (3) step();
    chk("rst_leds", leds(), 0);
    chk("rst_door", int'(bus.door_open), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_after_rst", int'({bus.led3, bus.led2, bus.led1, bus.door_open, bus.state_o}), 0);
    end

    // Held btn3 while moving: lamp at the 4th edge, exactly one pulse.
    bus.btn3 = 1'b1;
    repeat (3) step();
    chk("btn3_not_yet", leds(), 3'b000);
    step();
    chk("btn3_lit", leds(), 3'b100);
    repeat (4) step();
    bus.btn3 = 1'b0;
    repeat (5) step();
    chk("btn3_held_once", leds(), 3'b100);

    // Service floor 2: 8-cycle door, one CLOSE cycle; btn1 lights during OPEN.
    press(3'b010);
    chk("led2_lit", leds(), 3'b110);
    exp_q.push_back('{8, 2'b10});
    bus.floor = 2'b01; bus.moving = 1'b0;
    step();
    chk("f2_open_state", int'(bus.state_o), 1);
    chk("f2_led_clear", leds(), 3'b100);
    bus.btn1 = 1'b1;
    step();
    bus.btn1 = 1'b0;
    repeat (6) step();
    chk("f2_door_hi", int'(bus.door_open), 1);
    step();
    chk("f2_close", int'(bus.state_o), 2);
    step();
    chk("f2_idle", int'(bus.state_o), 0);
    chk("led1_set_in_open", leds(), 3'b101);

    // Service floor 1 with a re-arm at dwell cycle 5: 13 cycles total.
    exp_q.push_back('{13, 2'b10});
    bus.floor = 2'b00;
    step();
    chk("f1_open_state", int'(bus.state_o), 1);
    chk("f1_led_clear", leds(), 3'b100);
    step();
    bus.btn1 = 1'b1;
    step();
    bus.btn1 = 1'b0;
    repeat (10) step();
    chk("f1_door_hi_rearm", int'(bus.door_open), 1);
    step();
    chk("f1_close", int'(bus.state_o), 2);
    chk("f1_led_stays_off", leds(), 3'b100);
    step();
    chk("f1_idle", int'(bus.state_o), 0);

    // Press-triggered service at floor 1, aborted by moving at dwell cycle 3.
    exp_q.push_back('{3, 2'b00});
    bus.btn1 = 1'b1;
    step();
    bus.btn1 = 1'b0;
    repeat (3) step();
    chk("abort_open", int'(bus.state_o), 1);
    repeat (2) step();
    bus.moving = 1'b1;
    step();
    chk("abort_state", int'(bus.state_o), 0);
    chk("abort_door", int'(bus.door_open), 0);
    chk("abort_leds", leds(), 3'b100);

    // Floor 2'b11 never serves a lamp.
    press(3'b001);
    chk("led1_again", leds(), 3'b101);
    bus.floor = 2'b11; bus.moving = 1'b0;
    repeat (3) step();
    chk("floor11_idle", int'(bus.state_o), 0);
    chk("floor11_leds", leds(), 3'b101);

    // Reset in the middle of a floor-3 service.
    bus.floor = 2'b10;
    step();
    chk("f3_open", int'(bus.state_o), 1);
    chk("f3_led_clear", leds(), 3'b001);
    repeat (2) step();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_door", int'(bus.door_open), 0);
    chk("rst_mid_leds", leds(), 0);
    chk("rst_mid_state", int'(bus.state_o), 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Simultaneous presses on floors 1 and 3.
    bus.moving = 1'b1; bus.floor = 2'b00;
    press(3'b101);
    chk("simul_leds", leds(), 3'b101);

    // Second press on a lit lamp.
    press(3'b100);
`ifdef REQ_CANCEL_EN
    chk("cancel_first", leds(), 3'b001);
`else
    chk("cancel_first", leds(), 3'b101);
`endif
    press(3'b100);
    chk("cancel_second", leds(), 3'b101);

    repeat (3) step();
    chk("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/call_panel.md
Name: call_panel

Overview:
- Request-side counterpart of the goal-floor selector. Turns raw hall/cabin button presses into the per-floor request lamps `led1`, `led2` and `led3`. The selector reads these lamps.
- Owns the door dwell at a served floor and clears the request of that floor.
- Sits between the button inputs and the goal-floor logic. Shares the 2-bit floor encoding with the goal-floor logic.

Parameters:
- labelF1, 2'b00, encoding of floor 1
- labelF2, 2'b01, encoding of floor 2
- labelF3, 2'b10, encoding of floor 3
- DWELL_CYCLES, 8, clock cycles `door_open` stays high per service (legal range ≥2)

Ports:
- clk  input  1  single system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- btn1  input  1  raw floor-1 button, asynchronous to clk
- btn2  input  1  raw floor-2 button, asynchronous to clk
- btn3  input  1  raw floor-3 button, asynchronous to clk
- floor  input  2  current car floor, same encoding as the labels
- moving  input  1  car in motion
- led1  output  1  floor-1 request pending
- led2  output  1  floor-2 request pending
- led3  output  1  floor-3 request pending
- door_open  output  1  door open command
- state_o  output  2  FSM state, for debug (00=IDLE, 01=OPEN, 10=CLOSE)

Behaviour:
- Reset (async assert, sync release): outputs and internal state are
  - led1..3 = 0
  - door_open = 0
  - FSM = IDLE
  - dwell counter = 0
  - synchronizer and edge registers = 0
- Button path:
  - each btnN goes through a 2-flop synchronizer, then a rising-edge detect.
  - press_N is a one-cycle pulse, 3 cycles after the raw edge at the earliest.
  - a held button produces exactly one pulse.
- Lamp set: press_N sets ledN on the next clk edge. Exception: the FSM is in OPEN and floor == labelFN, in which case the press re-arms the dwell instead (see OPEN).
- Width rule: dwell counter width = $clog2(DWELL_CYCLES+1).
- IDLE state:
  - door_open = 0.
  - If ~moving and the lamp of the current floor is set (or a press pulse for the current floor arrives the same cycle), go to OPEN next cycle, load counter = DWELL_CYCLES-1, clear that lamp.
  - floor = 2'b11 never matches any lamp; stay in IDLE.
- OPEN state:
  - door_open = 1; counter decrements each cycle.
  - A press pulse for the current floor reloads the counter to DWELL_CYCLES-1; the lamp stays 0.
  - When counter == 0, go to CLOSE.
  - If moving asserts while in OPEN, go to IDLE immediately next cycle with door_open = 0 (safety abort). The cleared lamp is not restored.
- CLOSE state: door_open = 0 for exactly one cycle, then IDLE. This gives the goal-floor logic a lamp-stable cycle.
- Door timing: a service keeps door_open high for exactly DWELL_CYCLES cycles unless re-armed or aborted.
- Lamps of other floors: set/hold independently in every state.
- Simultaneous presses on several buttons in one cycle: all corresponding lamps are set.
- Lamps change only on clk edges, so led1..3 are glitch-free for the level-sensitive goal-floor logic.
- Reset mid-OPEN: door_open drops asynchronously and all lamps clear.

Optional Feature:
- Macro: REQ_CANCEL_EN.
- Defined: press_N while ledN is already 1 clears ledN (toggle cancel). The current-floor OPEN re-arm rule still takes priority.
- Undefined: press_N on a lit lamp has no effect; lamps clear only by service in IDLE→OPEN.

Test Plan:
1. Reset with btn1..3 = 0, then release rst_n → led1..3 = 0, door_open = 0, state_o = 00 for 10 cycles.
2. moving = 1, floor = 00, pulse btn3 high 5 cycles → led3 = 1 at cycle 4 after the raw edge. Holding btn3 3 more cycles gives no further change.
3. led2 = 1, then moving = 0, floor = 01 → next cycle state_o = 01 and led2 = 0. door_open = 1 for exactly 8 cycles, then state_o = 10 for 1 cycle, then 00.
4. In OPEN at floor 00, press btn1 at dwell cycle 5 → door_open high for 5 + 8 cycles total; led1 stays 0.
5. In OPEN, assert moving at dwell cycle 3 → door_open = 0 and state_o = 00 the next cycle. Separately, press btn1 and btn3 in the same cycle → led1 = led3 = 1.
6. With REQ_CANCEL_EN, press btn3 twice while moving → led3 goes 1 then 0. Without REQ_CANCEL_EN → led3 remains 1.
